// File: rtl/counter_pkg.sv
// Shared constants, direction encoding and load-clamp helper for the up/down modulo counter.
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Values above MOD-1 clamp to MOD-1; widened so MOD == 2**WIDTH compares correctly.
  function automatic logic [32:0] clamp_load(input logic [32:0] val, input logic [32:0] mod_v);
    return (val > (mod_v - 33'd1)) ? (mod_v - 33'd1) : val;
  endfunction

endpackage

// File: rtl/updown_next.sv
// Combinational next-count logic: load clamp, up/down step, wrap or saturate at the bounds.
module updown_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned MOD      = 128,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_next,
  output logic             bound_evt
);

  localparam int unsigned    W1    = WIDTH + 1;
  localparam logic [W1-1:0]  MAX_V = W1'(MOD - 1);

  logic [W1-1:0] q_ext;
  assign q_ext = {1'b0, q};

  always_comb begin
    q_next    = q;
    bound_evt = 1'b0;
    if (load) begin
      q_next = WIDTH'(clamp_load(33'(load_val), 33'(MOD)));
    end else if (en) begin
      if (up == DIR_UP) begin
        if (q_ext == MAX_V) begin
          bound_evt = 1'b1;
          q_next    = (SATURATE == MODE_SAT) ? q : '0;
        end else begin
          q_next = WIDTH'(q_ext + W1'(1));
        end
      end else begin
        if (q_ext == '0) begin
          bound_evt = 1'b1;
          q_next    = (SATURATE == MODE_SAT) ? q : WIDTH'(MAX_V);
        end else begin
          q_next = WIDTH'(q_ext - W1'(1));
        end
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// WIDTH-bit modulo-MOD up/down counter with load, wrap/saturate mode, terminal count and sticky overflow.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned MOD      = 128,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned   W1    = WIDTH + 1;
  localparam logic [W1-1:0] MAX_V = W1'(MOD - 1);

  if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH))) begin : g_bad_mod
    $error("updown_mod_counter: MOD must lie in [2, 2**WIDTH]");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             bound_evt;

  updown_next #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_next (
    .q         (q_q),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .q_next    (q_d),
    .bound_evt (bound_evt)
  );

  // A bound event wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (bound_evt) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = en & ((up == DIR_UP) ? ({1'b0, q_q} == MAX_V) : (q_q == '0));

endmodule
